// File: rtl/marv32_fetch_buffer.sv
// marv32_fetch_buffer
//   Instruction fetch buffer between the imem response port and the decoder.
//   Circular FIFO of {pc, instr} pairs with valid/ready handshakes on both
//   sides. A flush (or reset) empties the buffer in one cycle. The decoder's
//   flush input is driven high whenever no valid head exists, so an empty
//   buffer turns into a decoder bubble.
//
//   Optional feature macro: MARV32_FETCH_BUFFER_BYPASS_EN
//     When defined, an incoming word on an empty buffer is shown to the
//     decoder in the same cycle. If the decoder takes it, the word is never
//     written.
//
// Ports
//   clk_in, reset_in (sync, active high)
//   flush_in                         pipeline redirect, discards all entries
//   fetch_valid_in/pc_in/instr_in    imem response
//   fetch_ready_out                  buffer not full
//   dec_valid_out/ready_in           decoder handshake
//   dec_pc_out/instr_out             head entry (NOP_INSTR / 0 when empty)
//   dec_flush_out                    flush_in | ~dec_valid_out
//   count_out                        occupancy
module marv32_fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     flush_in,
  input  logic                     fetch_valid_in,
  input  logic [31:0]              fetch_pc_in,
  input  logic [31:0]              fetch_instr_in,
  output logic                     fetch_ready_out,
  output logic                     dec_valid_out,
  input  logic                     dec_ready_in,
  output logic [31:0]              dec_pc_out,
  output logic [31:0]              dec_instr_out,
  output logic                     dec_flush_out,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty, w_full, w_push, w_pop, w_byp;
  logic [63:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_head  = r_mem[r_rd_ptr];

`ifdef MARV32_FETCH_BUFFER_BYPASS_EN
  // Incoming word is forwarded straight to the decoder while empty.
  assign w_byp  = w_empty & fetch_valid_in & ~flush_in;
  // A forwarded word the decoder accepts is consumed without being stored.
  assign w_push = fetch_valid_in & ~w_full & ~flush_in & ~(w_byp & dec_ready_in);
`else
  assign w_byp  = 1'b0;
  assign w_push = fetch_valid_in & ~w_full & ~flush_in;
`endif
  // Pop only ever removes a stored entry; a bypassed word never counts here.
  assign w_pop  = ~w_empty & dec_ready_in & ~flush_in;

  // Full blocks the push even if a pop frees a slot in the same cycle.
  assign fetch_ready_out = ~w_full;
  assign dec_valid_out   = ~w_empty | w_byp;
  assign dec_flush_out   = flush_in | ~dec_valid_out;
  assign count_out       = r_count;

  always_comb begin
    dec_pc_out    = 32'h0;
    dec_instr_out = NOP_INSTR;
    if (!w_empty) begin
      dec_pc_out    = w_head[63:32];
      dec_instr_out = w_head[31:0];
    end else if (w_byp) begin
      dec_pc_out    = fetch_pc_in;
      dec_instr_out = fetch_instr_in;
    end
  end

  // Storage is not reset; count/pointers alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push && !reset_in) r_mem[r_wr_ptr] <= {fetch_pc_in, fetch_instr_in};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_marv32_fetch_buffer.sv
module tb_marv32_fetch_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, fl, fv, fr, dv, dr, dfl;
  logic [31:0] fpc, fins, dpc, dins;
  logic [2:0]  cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  marv32_fetch_buffer #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
    .clk_in(clk), .reset_in(rst), .flush_in(fl),
    .fetch_valid_in(fv), .fetch_pc_in(fpc), .fetch_instr_in(fins),
    .fetch_ready_out(fr), .dec_valid_out(dv), .dec_ready_in(dr),
    .dec_pc_out(dpc), .dec_instr_out(dins), .dec_flush_out(dfl),
    .count_out(cnt)
  );

  typedef struct {
    logic rst, fl, fv;
    logic [31:0] pc, ins;
    logic dr;
    logic fr, dv;
    logic [31:0] dpc, dins;
    logic dfl;
    logic [2:0] cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  typedef struct { logic [31:0] pc, ins; } item_t;
  item_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one stream of n words with PCs base, base+4, ...; decoder ready
  // is random when rnd_ready, else held high. The queue predicts order.
  task automatic stream(input int n, input logic [31:0] base, input bit rnd_ready,
                        input int max_cnt);
    int sent = 0, got = 0, cyc = 0;
    item_t it, ex;
    sbq.delete();
    while (got < n && cyc < 400) begin
      @(negedge clk);
      fv   = (sent < n);
      fpc  = base + 32'(sent * 4);
      fins = 32'h0000_0093 | (32'(sent) << 20);
      dr   = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (cnt > 3'(max_cnt)) chk("stream_count_bound", 32'(cnt), 32'(max_cnt));
      if (fv && fr) begin
        it.pc = fpc; it.ins = fins;
        sbq.push_back(it);
        sent++;
      end
      if (dv && dr) begin
        if (sbq.size() == 0) begin
          chk("stream_unexpected_pop", dpc, 32'hFFFF_FFFF);
        end else begin
          ex = sbq.pop_front();
          chk("stream_pc", dpc, ex.pc);
          chk("stream_instr", dins, ex.ins);
          got++;
        end
      end
      cyc++;
    end
    if (got < n) chk("stream_timeout_words", 32'(got), 32'(n));
    @(negedge clk);
    fv = 1'b0; dr = 1'b0;
  endtask

  initial begin
    // rst fl fv pc ins dr | fr dv dpc dins dfl cnt   (outputs seen before the edge)
    tbl[0]  = '{1,0,0,32'h0,  32'h0,        0, 1,0,32'h0,  NOP,          1,0};
    tbl[1]  = '{0,0,1,32'h100,32'h00500093, 0, 1,0,32'h0,  NOP,          1,0};
    tbl[2]  = '{0,0,0,32'h0,  32'h0,        0, 1,1,32'h100,32'h00500093, 0,1};
    tbl[3]  = '{0,0,1,32'h104,32'h00100113, 0, 1,1,32'h100,32'h00500093, 0,1};
    tbl[4]  = '{0,0,1,32'h108,32'h00200193, 0, 1,1,32'h100,32'h00500093, 0,2};
    tbl[5]  = '{0,0,1,32'h10c,32'h00300213, 0, 1,1,32'h100,32'h00500093, 0,3};
    tbl[6]  = '{0,0,1,32'h110,32'h00400293, 0, 0,1,32'h100,32'h00500093, 0,4};
    tbl[7]  = '{0,0,0,32'h0,  32'h0,        0, 0,1,32'h100,32'h00500093, 0,4};
    tbl[8]  = '{0,0,1,32'h114,32'h00500313, 1, 0,1,32'h100,32'h00500093, 0,4};
    tbl[9]  = '{0,0,0,32'h0,  32'h0,        0, 1,1,32'h104,32'h00100113, 0,3};
    tbl[10] = '{0,1,1,32'h118,32'h00600393, 1, 1,1,32'h104,32'h00100113, 1,3};
    tbl[11] = '{0,0,0,32'h0,  32'h0,        0, 1,0,32'h0,  NOP,          1,0};
    tbl[12] = '{0,0,1,32'h200,32'h00700413, 0, 1,0,32'h0,  NOP,          1,0};
    tbl[13] = '{1,0,0,32'h0,  32'h0,        0, 1,1,32'h200,32'h00700413, 0,1};
    tbl[14] = '{0,0,0,32'h0,  32'h0,        0, 1,0,32'h0,  NOP,          1,0};
`ifdef MARV32_FETCH_BUFFER_BYPASS_EN
    // Empty-buffer pushes are visible on the decoder side immediately.
    tbl[1].dv = 1; tbl[1].dpc = 32'h100; tbl[1].dins = 32'h00500093; tbl[1].dfl = 0;
    tbl[12].dv = 1; tbl[12].dpc = 32'h200; tbl[12].dins = 32'h00700413; tbl[12].dfl = 0;
`endif

    rst = 1; fl = 0; fv = 0; dr = 0; fpc = 0; fins = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; fl = tbl[i].fl; fv = tbl[i].fv;
      fpc = tbl[i].pc; fins = tbl[i].ins; dr = tbl[i].dr;
      #1;
      chk($sformatf("v%0d_fetch_ready", i), 32'(fr),   32'(tbl[i].fr));
      chk($sformatf("v%0d_dec_valid", i),   32'(dv),   32'(tbl[i].dv));
      chk($sformatf("v%0d_dec_pc", i),      dpc,       tbl[i].dpc);
      chk($sformatf("v%0d_dec_instr", i),   dins,      tbl[i].dins);
      chk($sformatf("v%0d_dec_flush", i),   32'(dfl),  32'(tbl[i].dfl));
      chk($sformatf("v%0d_count", i),       32'(cnt),  32'(tbl[i].cnt));
    end
    @(negedge clk);
    rst = 0; fl = 0; fv = 0; dr = 0;

`ifdef MARV32_FETCH_BUFFER_BYPASS_EN
    // Bypass: consumed in the same cycle, never stored.
    @(negedge clk);
    fv = 1; fpc = 32'h300; fins = 32'h00A00113; dr = 1;
    #1;
    chk("byp_valid", 32'(dv), 32'd1);
    chk("byp_instr", dins, 32'h00A00113);
    chk("byp_pc", dpc, 32'h300);
    chk("byp_flush", 32'(dfl), 32'd0);
    @(negedge clk);
    fv = 0; dr = 0;
    #1;
    chk("byp_count", 32'(cnt), 32'd0);
    chk("byp_not_stored", 32'(dv), 32'd0);
    stream(10, 32'h0, 1'b0, 0);
`else
    stream(10, 32'h0, 1'b0, 1);
`endif
    // Random decoder backpressure: fills, drains and wraps the pointers.
    stream(30, 32'h1000, 1'b1, 4);

    // Drain any leftover, then check empty state.
    @(negedge clk);
    fl = 1;
    @(negedge clk);
    fl = 0;
    #1;
    chk("final_count", 32'(cnt), 32'd0);
    chk("final_instr", dins, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
